// File: rtl/thread_regfile.sv
// Per-thread register file: R0-R12 general purpose, R13-R15 read-only block/thread identifiers.
// Operands are read into rs/rt in REQUEST; write-back happens in UPDATE.
module thread_regfile #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0,
  parameter int DATA_BITS         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           block_id,
  input  logic [2:0]           core_state,
  input  logic [3:0]           decoded_rd_address,
  input  logic [3:0]           decoded_rs_address,
  input  logic [3:0]           decoded_rt_address,
  input  logic                 decoded_reg_write_enable,
  input  logic [1:0]           decoded_reg_input_mux,
  input  logic [DATA_BITS-1:0] decoded_immediate,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  output logic [DATA_BITS-1:0] rs,
  output logic [DATA_BITS-1:0] rt
);

  typedef enum logic [2:0] {
    ST_REQUEST = 3'b011,
    ST_UPDATE  = 3'b110
  } core_state_e;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LSU  = 2'b01,
    SRC_IMM  = 2'b10,
    SRC_NONE = 2'b11
  } wb_src_e;

  logic [DATA_BITS-1:0] regs [16];
  logic [DATA_BITS-1:0] wb_data;
  logic                 wb_valid;
  logic                 do_write;
  logic                 do_read;

  always_comb begin
    wb_data  = '0;
    wb_valid = 1'b1;
    case (wb_src_e'(decoded_reg_input_mux))
      SRC_ALU:  wb_data = alu_out;
      SRC_LSU:  wb_data = lsu_out;
      SRC_IMM:  wb_data = decoded_immediate;
      default:  wb_valid = 1'b0;
    endcase
  end

  // Writes to R13-R15 are dropped silently by the address bound.
  assign do_write = enable && (core_state == ST_UPDATE) && decoded_reg_write_enable
                    && wb_valid && (decoded_rd_address <= 4'd12);
  assign do_read  = enable && (core_state == ST_REQUEST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 14; i++) begin
        regs[4'(i)] <= '0;
      end
      regs[14] <= DATA_BITS'(THREADS_PER_BLOCK);
      regs[15] <= DATA_BITS'(THREAD_ID);
      rs       <= '0;
      rt       <= '0;
    end else if (enable) begin
      regs[13] <= DATA_BITS'(block_id);
      if (do_write) begin
        regs[decoded_rd_address] <= wb_data;
      end
      if (do_read) begin
        rs <= regs[decoded_rs_address];
        rt <= regs[decoded_rt_address];
      end
    end
  end

endmodule

// File: tb/tb_thread_regfile.sv
// Directed bench for thread_regfile: stimulus pushes expected rs/rt into a queue,
// monitors pop and compare after the edge (or immediately, for async reset).
module tb_thread_regfile;

  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic [7:0]    block_id = '0;
  logic [2:0]    core_state = 3'b000;
  logic [3:0]    rd_a = '0, rs_a = '0, rt_a = '0;
  logic          we = 1'b0;
  logic [1:0]    mux = '0;
  logic [DB-1:0] imm = '0, alu = '0, lsu = '0;
  logic [DB-1:0] rs, rt;

  thread_regfile #(
    .THREADS_PER_BLOCK(4),
    .THREAD_ID(2),
    .DATA_BITS(DB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .block_id(block_id),
    .core_state(core_state),
    .decoded_rd_address(rd_a),
    .decoded_rs_address(rs_a),
    .decoded_rt_address(rt_a),
    .decoded_reg_write_enable(we),
    .decoded_reg_input_mux(mux),
    .decoded_immediate(imm),
    .alu_out(alu),
    .lsu_out(lsu),
    .rs(rs),
    .rt(rt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [DB-1:0] ers;
    logic [DB-1:0] ert;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic chk = 1'b0;
  logic chk_q = 1'b0;
  event imm_ev;

  task automatic compare(input string nm, input logic [DB-1:0] got, input logic [DB-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_underflow got 0 entries want 1");
    end else begin
      e = q.pop_front();
      compare({e.name, ".rs"}, rs, e.ers);
      compare({e.name, ".rt"}, rt, e.ert);
    end
  endtask

  // Edge monitor: checks outputs 1 time unit after any edge flagged by stimulus.
  always @(posedge clk) begin
    chk_q = chk;
    #1;
    if (chk_q) pop_check();
  end

  // Immediate monitor for between-edge checks (asynchronous reset).
  initial begin
    forever begin
      @(imm_ev);
      pop_check();
    end
  end

  task automatic cycle(input logic [2:0] st, input bit ck, input logic [DB-1:0] ers,
                       input logic [DB-1:0] ert, input string nm);
    core_state = st;
    chk = ck;
    if (ck) q.push_back('{nm, ers, ert});
    @(negedge clk);
    chk = 1'b0;
  endtask

  task automatic request(input logic [3:0] sa, input logic [3:0] ta, input logic [DB-1:0] ers,
                         input logic [DB-1:0] ert, input string nm);
    rs_a = sa;
    rt_a = ta;
    we   = 1'b0;
    cycle(3'b011, 1'b1, ers, ert, nm);
  endtask

  task automatic update(input logic [3:0] rd, input logic [1:0] m, input logic [DB-1:0] i,
                        input logic [DB-1:0] a, input logic [DB-1:0] l);
    rd_a = rd;
    mux  = m;
    imm  = i;
    alu  = a;
    lsu  = l;
    we   = 1'b1;
    cycle(3'b110, 1'b0, '0, '0, "");
    we   = 1'b0;
  endtask

  initial begin
    #1;
    q.push_back('{"reset_state", 8'h00, 8'h00});
    -> imm_ev;
    @(negedge clk);
    reset = 1'b0;

    request(4'd14, 4'd15, 8'h04, 8'h02, "blockdim_threadidx");
    request(4'd0, 4'd13, 8'h00, 8'h00, "r0_r13_after_reset");

    update(4'd3, 2'b10, 8'h5A, 8'h00, 8'h00);
    request(4'd3, 4'd3, 8'h5A, 8'h5A, "wb_imm_same_addr");
    update(4'd3, 2'b00, 8'h00, 8'h11, 8'h00);
    request(4'd3, 4'd0, 8'h11, 8'h00, "wb_alu");
    update(4'd3, 2'b01, 8'h00, 8'h00, 8'hC3);
    request(4'd3, 4'd14, 8'hC3, 8'h04, "wb_lsu");

    update(4'd15, 2'b10, 8'hFF, 8'hFF, 8'hFF);
    request(4'd15, 4'd3, 8'h02, 8'hC3, "r15_write_dropped");
    update(4'd5, 2'b10, 8'h66, 8'h00, 8'h00);
    request(4'd5, 4'd12, 8'h66, 8'h00, "r5_written");
    update(4'd5, 2'b11, 8'h99, 8'h99, 8'h99);
    request(4'd5, 4'd5, 8'h66, 8'h66, "mux11_no_write");

    block_id = 8'd7;
    cycle(3'b000, 1'b0, '0, '0, "");
    request(4'd13, 4'd12, 8'h07, 8'h00, "r13_block_id");

    rd_a = 4'd4; mux = 2'b10; imm = 8'h44; we = 1'b1;
    cycle(3'b101, 1'b1, 8'h07, 8'h00, "execute_hold");
    we = 1'b0;
    request(4'd4, 4'd13, 8'h00, 8'h07, "execute_write_ignored");

    enable = 1'b0;
    block_id = 8'd9;
    request(4'd3, 4'd5, 8'h00, 8'h07, "disabled_request_frozen");
    rd_a = 4'd6; mux = 2'b10; imm = 8'h77; we = 1'b1;
    cycle(3'b110, 1'b1, 8'h00, 8'h07, "disabled_update_frozen");
    we = 1'b0;
    enable = 1'b1;
    request(4'd13, 4'd6, 8'h07, 8'h00, "r13_frozen_no_write");
    request(4'd13, 4'd13, 8'h09, 8'h09, "r13_refreshed");

    update(4'd2, 2'b10, 8'h33, 8'h00, 8'h00);
    request(4'd2, 4'd2, 8'h33, 8'h33, "r2_written");
    #2 reset = 1'b1;
    #1;
    q.push_back('{"async_reset", 8'h00, 8'h00});
    -> imm_ev;
    #1 reset = 1'b0;
    request(4'd2, 4'd14, 8'h00, 8'h04, "r2_cleared");
    request(4'd15, 4'd13, 8'h02, 8'h09, "post_reset_normal");

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/thread_regfile.md
THREAD_REGFILE -- requirements
Module: thread_regfile

Interface
REQ-001 Parameter THREADS_PER_BLOCK, default 4, block size; reset value of R14.
REQ-002 Parameter THREAD_ID, default 0, index of this thread within the block; reset value of R15.
REQ-003 Parameter DATA_BITS, default 8, width of every register and data port.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears state immediately, independent of clk.
REQ-006 enable  input  1  thread active in current block; low freezes all state.
REQ-007 block_id  input  8  index of block currently executing on the core.
REQ-008 core_state  input  3  core FSM state: 011 REQUEST, 110 UPDATE; all other codes are no-op here.
REQ-009 decoded_rd_address, decoded_rs_address, decoded_rt_address  input  4 each  destination / source register indices.
REQ-010 decoded_reg_write_enable  input  1  current instruction writes rd.
REQ-011 decoded_reg_input_mux  input  2  write-back source: 00 ALU, 01 LSU, 10 immediate, 11 reserved.
REQ-012 decoded_immediate  input  DATA_BITS  constant operand for write-back.
REQ-013 alu_out  input  DATA_BITS  ALU result, stable from EXECUTE through UPDATE.
REQ-014 lsu_out  input  DATA_BITS  load data, stable in UPDATE.
REQ-015 rs, rt  output  DATA_BITS each  registered operands to the ALU and LSU.

Function
REQ-016 Storage SHALL be 16 registers R0-R15 of DATA_BITS each.
REQ-017 R0-R12 SHALL be general purpose and software-writable.
REQ-018 R13 (blockIdx), R14 (blockDim) and R15 (threadIdx) SHALL be read-only to software.
REQ-019 When enable=1, R13 SHALL load block_id on every rising edge, regardless of core_state.
REQ-020 When enable=1 and core_state=REQUEST, rs SHALL load R[decoded_rs_address] and rt SHALL load R[decoded_rt_address] on the edge, one-cycle latency.
REQ-021 rs and rt SHALL hold their values in every state other than REQUEST.
REQ-022 When enable=1, core_state=UPDATE, decoded_reg_write_enable=1 and decoded_rd_address<=12, R[rd] SHALL load alu_out (mux 00), lsu_out (mux 01) or decoded_immediate (mux 10) on the edge.
REQ-023 Mux code 11 SHALL perform no write.
REQ-024 A write whose decoded_rd_address is 13-15 SHALL be silently dropped; no flag is raised.
REQ-025 Write data SHALL be taken bit-exact; no extension or saturation (DATA_BITS in, DATA_BITS out).
REQ-026 Writes SHALL be ignored in any state other than UPDATE, even if decoded_reg_write_enable=1.
REQ-027 A register written in UPDATE SHALL be visible to the next instruction's REQUEST read; no bypass is required, because REQUEST never coincides with UPDATE.
REQ-028 rs_address equal to rt_address SHALL return the same value on both ports.
REQ-029 When enable=0, no register, rs or rt SHALL change, including R13.
REQ-030 Behaviour for core_state codes other than REQUEST and UPDATE SHALL be a no-op except for the R13 refresh.

Reset
REQ-031 While reset=1, R0-R13 SHALL be 0, R14 SHALL be THREADS_PER_BLOCK, R15 SHALL be THREAD_ID, and rs=rt=0.
REQ-032 Reset SHALL take effect asynchronously, mid-instruction included.
REQ-033 Reset SHALL override enable and any pending write.
REQ-034 The first edge after reset deasserts SHALL behave as normal operation.

Verification
REQ-035 Reset with THREADS_PER_BLOCK=4, THREAD_ID=2; REQUEST with rs=14, rt=15 -> rs=4, rt=2 one edge later.
REQ-036 UPDATE, rd=3, mux=10, immediate=0x5A, then REQUEST rs=3 -> rs=0x5A; repeat with mux=00, alu_out=0x11 -> rs=0x11; repeat with mux=01, lsu_out=0xC3 -> rs=0xC3.
REQ-037 UPDATE, rd=15, mux=10, immediate=0xFF -> R15 unchanged (reads THREAD_ID); mux=11 with rd=5 -> R5 unchanged.
REQ-038 block_id=7, enable=1, one edge, then REQUEST rs=13 -> rs=7; enable=0, block_id=9 -> R13 stays 7, rs/rt frozen through REQUEST and UPDATE.
REQ-039 write_enable=1, rd=4 while core_state=EXECUTE (101) -> R4 unchanged.
REQ-040 Reset pulsed asynchronously between edges after R2=0x33 written -> R2=0, rs=rt=0 immediately, before the next edge.
